// File: rtl/instruction_issue.sv
// Issue stage for the add_subtract ALU: decodes 8-bit instructions, drives the ALU
// operands, waits out the ALU latency and writes the result back into a 4-entry register file.
module instruction_issue #(
    parameter int WIDTH   = 4,
    parameter int NREGS   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    output logic             instr_ready,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDI = 4'b1111;
    localparam logic [2:0] LAT    = 3'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [2:0]       cnt, cnt_next;
    logic [1:0]       wb_addr, wb_addr_next;
    logic [WIDTH-1:0] regs [NREGS];

    logic             ready_next, busy_next, done_next;
    logic [3:0]       op_next;
    logic [WIDTH-1:0] a_next, b_next;

    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [3:0]       dec_op;
    logic [1:0]       dec_rd, dec_rs;
    logic             accept;

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1; the source holds instr stable until then. instr_ready
    // is registered and only ever high in IDLE, so there is no combinational path
    // from instr_valid back to instr_ready.
    assign accept  = instr_valid && instr_ready;
    assign dec_op  = instr[7:4];
    assign dec_rd  = instr[3:2];
    assign dec_rs  = instr[1:0];
    assign rd_data = regs[rd_sel];

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        wb_addr_next = wb_addr;
        ready_next   = instr_ready;
        busy_next    = busy;
        done_next    = 1'b0;
        op_next      = alu_op;
        a_next       = alu_a;
        b_next       = alu_b;
        wr_en        = 1'b0;
        wr_addr      = dec_rd;
        wr_data      = '0;

        case (state)
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    if (dec_op == OP_NOP) begin
                        done_next = 1'b1;
                    end else if (dec_op == OP_LDI) begin
                        done_next = 1'b1;
                        wr_en     = 1'b1;
                        wr_addr   = dec_rd;
                        wr_data   = {{(WIDTH-2){1'b0}}, dec_rs};
                    end else begin
                        // Both operands are sampled before any write, so rd==rs reads the old value.
                        op_next      = dec_op;
                        a_next       = regs[dec_rd];
                        b_next       = regs[dec_rs];
                        wb_addr_next = dec_rd;
                        ready_next   = 1'b0;
                        busy_next    = 1'b1;
                        cnt_next     = LAT;
                        state_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = WB;
                end
            end
            WB: begin
                wr_en      = 1'b1;
                wr_addr    = wb_addr;
                wr_data    = alu_result;
                op_next    = 4'b0000;
                busy_next  = 1'b0;
                ready_next = 1'b1;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wb_addr     <= '0;
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            wb_addr     <= wb_addr_next;
            instr_ready <= ready_next;
            busy        <= busy_next;
            done        <= done_next;
            alu_op      <= op_next;
            alu_a       <= a_next;
            alu_b       <= b_next;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_instruction_issue.sv
// Self-checking bench for instruction_issue with a latency-accurate add/subtract ALU
// and a register-level reference model of the instruction set.
module tb_instruction_issue;

    localparam int WIDTH   = 4;
    localparam int NREGS   = 4;
    localparam int ALU_LAT = 1;
    localparam int MOD     = 1 << WIDTH;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             instr_valid = 1'b0;
    logic [7:0]       instr = 8'h00;
    logic             instr_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [1:0]       rd_sel = 2'd0;
    logic [WIDTH-1:0] rd_data;
    logic             busy, done;

    int n_checks = 0;
    int n_fails  = 0;
    logic [WIDTH-1:0] ref_regs [NREGS];
    logic [WIDTH-1:0] exp_q [$];

    instruction_issue #(.WIDTH(WIDTH), .NREGS(NREGS), .ALU_LAT(ALU_LAT)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .rd_sel(rd_sel), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    // Clock / reset block and the external ALU: odd opcodes subtract, even opcodes add.
    always #5 clock = ~clock;

    logic [WIDTH-1:0] alu_pipe [ALU_LAT];
    always_ff @(posedge clock) begin
        alu_pipe[0] <= alu_op[0] ? alu_a - alu_b : alu_a + alu_b;
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int r;
        r = op[0] ? int'(a) - int'(b) : int'(a) + int'(b);
        r = ((r % MOD) + MOD) % MOD;
        return WIDTH'(r);
    endfunction

    // Driver tasks
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [WIDTH-1:0] v);
        rd_sel = sel;
        #1;
        v = rd_data;
    endtask

    task automatic drive_instr(input logic [7:0] ins, output bit accepted, output int lat,
                               output logic [2*WIDTH+6:0] issue_snap, output logic [6:0] retire_snap);
        int n;
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        accepted = (instr_ready === 1'b1);
        lat = 0;
        issue_snap = '0;
        retire_snap = '0;
        if (!accepted) begin
            instr_valid = 1'b0;
            return;
        end
        cycle();
        instr_valid = 1'b0;
        issue_snap = {alu_op, alu_a, alu_b, busy, instr_ready, done};
        while (done !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        retire_snap = {done, busy, instr_ready, alu_op};
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_checks++;
            if ({instr_ready, busy, done, alu_op, alu_a, alu_b} !== '0) begin
                n_fails++;
                $display("FAIL reset_outputs: got ready=%b busy=%b done=%b op=%h a=%h b=%h, required all 0",
                         instr_ready, busy, done, alu_op, alu_a, alu_b);
            end
        end
        for (int r = 0; r < NREGS; r++) begin
            read_reg(2'(r), v);
            n_checks++;
            if (v !== '0) begin
                n_fails++;
                $display("FAIL reset_reg%0d: got %h required 0", r, v);
            end
            ref_regs[r] = '0;
        end
        reset = 1'b0;
        n_checks++;
        if (instr_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL ready_before_edge: got %b required 0", instr_ready);
        end
        cycle();
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL ready_after_release: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_ldi_back_to_back();
        logic [WIDTH-1:0] v0, v1;
        instr_valid = 1'b1;
        instr = 8'hF3;
        cycle();
        read_reg(2'd0, v0);
        ref_regs[0] = 4'd3;
        n_checks++;
        if ({done, instr_ready, v0} !== {1'b1, 1'b1, ref_regs[0]}) begin
            n_fails++;
            $display("FAIL ldi_first: got done=%b ready=%b R0=%h, required 1 1 %h", done, instr_ready, v0, ref_regs[0]);
        end
        instr = 8'hF5;
        cycle();
        instr_valid = 1'b0;
        read_reg(2'd0, v0);
        read_reg(2'd1, v1);
        ref_regs[1] = 4'd1;
        n_checks++;
        if ({done, instr_ready, v0, v1} !== {1'b1, 1'b1, ref_regs[0], ref_regs[1]}) begin
            n_fails++;
            $display("FAIL ldi_second: got done=%b ready=%b R0=%h R1=%h, required 1 1 %h %h",
                     done, instr_ready, v0, v1, ref_regs[0], ref_regs[1]);
        end
        cycle();
        n_checks++;
        if ({done, instr_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL ldi_idle: got done=%b ready=%b, required 0 1", done, instr_ready);
        end
    endtask

    task automatic test_add();
        bit acc;
        int lat;
        logic [2*WIDTH+6:0] is;
        logic [6:0] rs;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] exp_v;
        exp_v = ref_alu(4'b0010, ref_regs[0], ref_regs[1]);
        drive_instr(8'h21, acc, lat, is, rs);
        n_checks++;
        if (!acc) begin
            n_fails++;
            $display("FAIL add_accept: got not accepted, required accepted");
        end
        n_checks++;
        if (is !== {4'b0010, ref_regs[0], ref_regs[1], 1'b1, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL add_issue: got %h required %h", is, {4'b0010, ref_regs[0], ref_regs[1], 3'b100});
        end
        n_checks++;
        if (lat !== ALU_LAT + 1) begin
            n_fails++;
            $display("FAIL add_latency: got %0d required %0d", lat, ALU_LAT + 1);
        end
        n_checks++;
        if (rs !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
            n_fails++;
            $display("FAIL add_retire: got done/busy/ready/op=%b required 1010000", rs);
        end
        ref_regs[0] = exp_v;
        read_reg(2'd0, v);
        n_checks++;
        if (v !== 4'd4 || v !== ref_regs[0]) begin
            n_fails++;
            $display("FAIL add_result: got R0=%h required 4", v);
        end
        cycle();
        n_checks++;
        if (done !== 1'b0) begin
            n_fails++;
            $display("FAIL add_done_pulse: got done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_wrap();
        bit acc;
        int lat;
        logic [2*WIDTH+6:0] is;
        logic [6:0] rs;
        logic [WIDTH-1:0] v;
        int model;
        drive_instr(8'hF3, acc, lat, is, rs);
        ref_regs[0] = 4'd3;
        model = 3;
        for (int k = 0; k < 3; k++) begin
            drive_instr(8'h20, acc, lat, is, rs);
            n_checks++;
            if (is[2*WIDTH+2:WIDTH+3] !== WIDTH'(model) || is[WIDTH+2:3] !== WIDTH'(model)) begin
                n_fails++;
                $display("FAIL wrap_operands%0d: got a=%h b=%h required both %h", k,
                         is[2*WIDTH+2:WIDTH+3], is[WIDTH+2:3], WIDTH'(model));
            end
            model = (2 * model) % MOD;
            read_reg(2'd0, v);
            n_checks++;
            if (v !== WIDTH'(model)) begin
                n_fails++;
                $display("FAIL wrap_result%0d: got R0=%h required %h", k, v, WIDTH'(model));
            end
        end
        ref_regs[0] = WIDTH'(model);
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] exp_v;
        exp_v = ref_alu(4'b0010, ref_regs[0], ref_regs[1]);
        instr = 8'h21;
        instr_valid = 1'b1;
        cycle();
        instr = 8'hF2;
        for (int i = 0; i < ALU_LAT; i++) begin
            cycle();
            read_reg(2'd0, v);
            n_checks++;
            if (instr_ready !== 1'b0 || v !== ref_regs[0]) begin
                n_fails++;
                $display("FAIL stall_wait%0d: got ready=%b R0=%h, required 0 %h", i, instr_ready, v, ref_regs[0]);
            end
        end
        cycle();
        read_reg(2'd0, v);
        n_checks++;
        if ({done, instr_ready, v} !== {1'b1, 1'b1, exp_v}) begin
            n_fails++;
            $display("FAIL stall_wb: got done=%b ready=%b R0=%h, required 1 1 %h", done, instr_ready, v, exp_v);
        end
        cycle();
        instr_valid = 1'b0;
        read_reg(2'd0, v);
        n_checks++;
        if ({done, v} !== {1'b1, 4'd2}) begin
            n_fails++;
            $display("FAIL stall_ldi: got done=%b R0=%h, required 1 2", done, v);
        end
        ref_regs[0] = 4'd2;
    endtask

    task automatic test_reset_mid();
        bit acc;
        int lat;
        int pulses;
        logic [2*WIDTH+6:0] is;
        logic [6:0] rs;
        logic [WIDTH-1:0] v;
        instr = 8'h21;
        instr_valid = 1'b1;
        cycle();
        instr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({instr_ready, busy, done, alu_op, alu_a, alu_b} !== '0) begin
            n_fails++;
            $display("FAIL midreset_outputs: got ready=%b busy=%b done=%b op=%h a=%h b=%h, required all 0",
                     instr_ready, busy, done, alu_op, alu_a, alu_b);
        end
        for (int r = 0; r < NREGS; r++) begin
            read_reg(2'(r), v);
            n_checks++;
            if (v !== '0) begin
                n_fails++;
                $display("FAIL midreset_reg%0d: got %h required 0", r, v);
            end
            ref_regs[r] = '0;
        end
        pulses = 0;
        cycle();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < ALU_LAT + 3; c++) begin
            cycle();
            if (done === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fails++;
            $display("FAIL midreset_no_done: got %0d done pulses required 0", pulses);
        end
        drive_instr(8'hF6, acc, lat, is, rs);
        read_reg(2'd1, v);
        ref_regs[1] = 4'd2;
        n_checks++;
        if (!acc || lat != 0 || v !== ref_regs[1]) begin
            n_fails++;
            $display("FAIL midreset_ldi: got acc=%b lat=%0d R1=%h, required 1 0 %h", acc, lat, v, ref_regs[1]);
        end
    endtask

    task automatic test_random();
        bit acc;
        int lat;
        logic [2*WIDTH+6:0] is;
        logic [6:0] rs;
        logic [WIDTH-1:0] v;
        logic [7:0] ins;
        logic [3:0] op;
        logic [1:0] rd, rb;
        bit is_alu;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       op = 4'h0;
                1:       op = 4'hF;
                default: op = 4'($urandom_range(1, 14));
            endcase
            rd = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            ins = {op, rd, rb};
            is_alu = (op != 4'h0) && (op != 4'hF);
            if (op == 4'hF) exp_q.push_back({{(WIDTH-2){1'b0}}, rb});
            else if (is_alu) exp_q.push_back(ref_alu(op, ref_regs[rd], ref_regs[rb]));
            drive_instr(ins, acc, lat, is, rs);
            n_checks++;
            if (!acc || lat != (is_alu ? ALU_LAT + 1 : 0) || rs[6] !== 1'b1) begin
                n_fails++;
                $display("FAIL rand_timing%0d: instr=%h acc=%b lat=%0d done=%b, required 1 %0d 1",
                         t, ins, acc, lat, rs[6], is_alu ? ALU_LAT + 1 : 0);
            end
            if (is_alu) begin
                n_checks++;
                if (is[2*WIDTH+6:3] !== {op, ref_regs[rd], ref_regs[rb]}) begin
                    n_fails++;
                    $display("FAIL rand_issue%0d: got op/a/b=%h required %h", t,
                             is[2*WIDTH+6:3], {op, ref_regs[rd], ref_regs[rb]});
                end
            end
            if (op != 4'h0) ref_regs[rd] = exp_q.pop_front();
            for (int r = 0; r < NREGS; r++) begin
                read_reg(2'(r), v);
                n_checks++;
                if (v !== ref_regs[r]) begin
                    n_fails++;
                    $display("FAIL rand_reg%0d_%0d: instr=%h got %h required %h", t, r, ins, v, ref_regs[r]);
                end
            end
            repeat ($urandom_range(0, 2)) cycle();
        end
    endtask

    initial begin
        test_reset();
        test_ldi_back_to_back();
        test_add();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
